// File: rtl/led_pwm_periph.sv
// Memory-mapped LED PWM peripheral on the picorv32 native bus.
// Per-LED 8-bit duty, shared tick prescaler, enable/invert, heartbeat on DEBUG_LED.
module led_pwm_periph #(
   parameter int unsigned NUM_LEDS   = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                mem_valid,
   input  logic [31:0]         mem_addr,
   input  logic [31:0]         mem_wdata,
   input  logic [3:0]          mem_wstrb,
   output logic                mem_ready,
   output logic [31:0]         mem_rdata,
   output logic [NUM_LEDS-1:0] LED,
   output logic                DEBUG_LED
);

   localparam int unsigned OFF_W    = 4;
   localparam int unsigned PWM_W    = 8;
   localparam int unsigned OFF_DUTY = 4;
   localparam logic [OFF_W-1:0] OFF_CTRL = OFF_W'(0);
   localparam logic [OFF_W-1:0] OFF_PRE  = OFF_W'(1);
   localparam logic [OFF_W-1:0] OFF_STAT = OFF_W'(2);

   logic                           ready_q, ready_d;
   logic                           acked_q, acked_d;
   logic [31:0]                    rdata_q, rdata_d;
   logic                           en_q, en_d;
   logic                           inv_q, inv_d;
   logic [PRESCALE_W-1:0]          prescale_q, prescale_d;
   logic [PRESCALE_W-1:0]          pre_cnt_q, pre_cnt_d;
   logic [PWM_W-1:0]               pwm_q, pwm_d;
   logic                           dbg_q, dbg_d;
   logic [NUM_LEDS-1:0][PWM_W-1:0] duty_q, duty_d;
   logic [NUM_LEDS-1:0]            led_q, led_d;

   logic             sel_c, commit_c, wr_c, tick_c;
   logic [OFF_W-1:0] off_c;
   logic [31:0]      wmask_c, rd_word_c;
   logic             unused_c;

   assign sel_c    = mem_valid & (mem_addr[31:6] == BASE_ADDR[31:6]);
   assign off_c    = mem_addr[5:2];
   // A request still held after its ack is not acknowledged again until valid drops.
   assign commit_c = sel_c & ~ready_q & ~acked_q;
   assign wr_c     = commit_c & (|mem_wstrb);
   assign tick_c   = en_q & (pre_cnt_q == prescale_q);
   assign wmask_c  = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
   assign unused_c = ^{mem_addr[1:0], mem_wdata, wmask_c};

   // Register read mux
   always_comb begin
      rd_word_c = '0;
      case (off_c)
         OFF_CTRL: rd_word_c[1:0] = {inv_q, en_q};
         OFF_PRE:  rd_word_c[PRESCALE_W-1:0] = prescale_q;
         OFF_STAT: rd_word_c[PWM_W:0] = {dbg_q, pwm_q};
         default: begin
            for (int i = 0; i < NUM_LEDS; i++) begin
               if (off_c == OFF_W'(OFF_DUTY + i)) rd_word_c[PWM_W-1:0] = duty_q[i];
            end
         end
      endcase
   end

   // Next-state: bus handshake, counters, register writes, LED stage
   always_comb begin
      ready_d    = commit_c;
      acked_d    = sel_c & (acked_q | ready_q);
      rdata_d    = commit_c ? rd_word_c : 32'h0;
      en_d       = en_q;
      inv_d      = inv_q;
      prescale_d = prescale_q;
      pre_cnt_d  = pre_cnt_q;
      pwm_d      = pwm_q;
      dbg_d      = dbg_q;
      duty_d     = duty_q;
      led_d      = '0;

      if (!en_q) begin
         pre_cnt_d = '0;
         pwm_d     = '0;
      end else begin
         pre_cnt_d = tick_c ? '0 : pre_cnt_q + PRESCALE_W'(1);
         if (tick_c) begin
            pwm_d = pwm_q + PWM_W'(1);
            if (pwm_q == {PWM_W{1'b1}}) dbg_d = ~dbg_q;
         end
      end

      // Writes land alongside the counter step, so counting uses the old settings.
      if (wr_c) begin
         case (off_c)
            OFF_CTRL: if (mem_wstrb[0]) {inv_d, en_d} = mem_wdata[1:0];
            OFF_PRE: begin
               prescale_d = (prescale_q & ~wmask_c[PRESCALE_W-1:0]) |
                            (mem_wdata[PRESCALE_W-1:0] & wmask_c[PRESCALE_W-1:0]);
               pre_cnt_d  = '0;
            end
            default: begin
               for (int i = 0; i < NUM_LEDS; i++) begin
                  if (off_c == OFF_W'(OFF_DUTY + i) && mem_wstrb[0])
                     duty_d[i] = mem_wdata[PWM_W-1:0];
               end
            end
         endcase
      end

      for (int i = 0; i < NUM_LEDS; i++) begin
         led_d[i] = (en_q & (pwm_q < duty_q[i])) ^ inv_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q    <= 1'b0;
         acked_q    <= 1'b0;
         rdata_q    <= '0;
         en_q       <= 1'b0;
         inv_q      <= 1'b0;
         prescale_q <= '0;
         pre_cnt_q  <= '0;
         pwm_q      <= '0;
         dbg_q      <= 1'b0;
         duty_q     <= '0;
         led_q      <= '0;
      end else begin
         ready_q    <= ready_d;
         acked_q    <= acked_d;
         rdata_q    <= rdata_d;
         en_q       <= en_d;
         inv_q      <= inv_d;
         prescale_q <= prescale_d;
         pre_cnt_q  <= pre_cnt_d;
         pwm_q      <= pwm_d;
         dbg_q      <= dbg_d;
         duty_q     <= duty_d;
         led_q      <= led_d;
      end
   end

   assign mem_ready = ready_q;
   assign mem_rdata = rdata_q;
   assign LED       = led_q;
   assign DEBUG_LED = dbg_q;

endmodule

// File: tb/tb_led_pwm_periph.sv
// Scoreboard bench for led_pwm_periph: reads queue expected data, a negedge monitor
// pops and compares on every mem_ready; waveform properties are checked inline.
module tb_led_pwm_periph;

   localparam logic [31:0] BASE = 32'h0300_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [7:0]  LED;
   logic        DEBUG_LED;

   typedef struct {
      logic        chk;
      logic [31:0] val;
      logic [31:0] mask;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   led_pwm_periph #(
      .NUM_LEDS(8), .BASE_ADDR(BASE), .PRESCALE_W(16)
   ) dut (
      .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .LED(LED), .DEBUG_LED(DEBUG_LED)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every acknowledged transfer consumes one scoreboard entry
   always @(negedge clk) begin : mon
      exp_t e;
      if (mem_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: got ack with empty scoreboard, rdata %h", mem_rdata);
         end else begin
            e = exp_q.pop_front();
            if (e.chk) check("rdata", mem_rdata & e.mask, e.val);
         end
      end
   end

   task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bit got = 1'b0;
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (mem_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      mem_valid = 1'b0; mem_wstrb = 4'h0;
      check("ack_seen", 32'(got), 32'd1);
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      exp_q.push_back('{chk: 1'b0, val: 32'h0, mask: 32'h0});
      xfer(a, d, s);
   endtask

   task automatic bus_rd(input logic [31:0] a, input logic [31:0] v, input logic [31:0] m);
      exp_q.push_back('{chk: 1'b1, val: v, mask: m});
      xfer(a, 32'h0, 4'h0);
   endtask

   // Cycles between two consecutive DEBUG_LED toggles (bounded)
   task automatic dbg_gap(output int gap);
      logic p;
      int   n = 0;
      @(negedge clk);
      p = DEBUG_LED;
      while (DEBUG_LED === p && n < 3000) begin
         @(negedge clk);
         n++;
      end
      p = DEBUG_LED;
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (DEBUG_LED === p && gap < 3000);
   endtask

   initial begin
      int c0, c1, c2, gap, w;
      logic exp_hs [4];
      exp_hs[0] = 1'b0; exp_hs[1] = 1'b1; exp_hs[2] = 1'b0; exp_hs[3] = 1'b0;

      // Reset held with a pending request
      reset = 1'b1; mem_valid = 1'b1; mem_addr = BASE; mem_wdata = '0; mem_wstrb = '0;
      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         check("rst_ready", 32'(mem_ready), 32'd0);
         check("rst_led", 32'(LED), 32'd0);
         check("rst_dbg", 32'(DEBUG_LED), 32'd0);
      end
      @(posedge clk); #1;
      reset = 1'b0; mem_valid = 1'b0;
      bus_rd(BASE, 32'h0, 32'hFFFF_FFFF);

      // Request held for 4 cycles is acknowledged exactly once
      exp_q.push_back('{chk: 1'b1, val: 32'h0, mask: 32'hFFFF_FFFF});
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_addr = BASE; mem_wstrb = 4'h0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("held_ready_c%0d", i + 1), 32'(mem_ready), 32'(exp_hs[i]));
      end
      @(posedge clk); #1;
      mem_valid = 1'b0;

      // Outside the window: no ack, rdata stays 0
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_addr = 32'h0400_0000;
      repeat (3) begin
         @(negedge clk);
         check("unsel_ready", 32'(mem_ready), 32'd0);
         check("unsel_rdata", mem_rdata, 32'h0);
      end
      @(posedge clk); #1;
      mem_valid = 1'b0;

      // Byte strobes, unmapped offset
      bus_wr(BASE + 32'h04, 32'h0000_1234, 4'hF);
      bus_wr(BASE + 32'h04, 32'h0000_00AB, 4'h1);
      bus_rd(BASE + 32'h04, 32'h0000_12AB, 32'hFFFF_FFFF);
      bus_wr(BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF);
      bus_rd(BASE + 32'h0C, 32'h0, 32'hFFFF_FFFF);

      // Basic PWM, prescale 0
      bus_wr(BASE + 32'h10, 32'h40, 4'hF);
      bus_wr(BASE + 32'h14, 32'h00, 4'hF);
      bus_wr(BASE + 32'h18, 32'hFF, 4'hF);
      bus_wr(BASE + 32'h04, 32'h0, 4'hF);
      bus_rd(BASE + 32'h10, 32'h40, 32'hFFFF_FFFF);
      bus_wr(BASE + 32'h00, 32'h1, 4'hF);
      repeat (4) @(posedge clk);
      c0 = 0; c1 = 0; c2 = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         c0 += int'(LED[0]); c1 += int'(LED[1]); c2 += int'(LED[2]);
      end
      check("pwm_led0_high", 32'(c0), 32'd64);
      check("pwm_led1_high", 32'(c1), 32'd0);
      check("pwm_led2_high", 32'(c2), 32'd255);
      dbg_gap(gap);
      check("dbg_period_256", 32'(gap), 32'd256);

      // Prescale 3 with invert
      bus_wr(BASE + 32'h00, 32'h0, 4'hF);
      bus_wr(BASE + 32'h10, 32'h80, 4'hF);
      bus_wr(BASE + 32'h04, 32'h3, 4'hF);
      bus_wr(BASE + 32'h00, 32'h3, 4'hF);
      repeat (8) @(posedge clk);
      c0 = 0;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         c0 += int'(LED[0]);
      end
      check("inv_led0_high", 32'(c0), 32'd512);
      dbg_gap(gap);
      check("dbg_period_1024", 32'(gap), 32'd1024);
      bus_wr(BASE + 32'h00, 32'h2, 4'hF);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("disabled_inv_led", 32'(LED), 32'hFF);
      bus_rd(BASE + 32'h08, 32'h0, 32'h0000_00FF);

      // Reset in the middle of a PWM period
      bus_wr(BASE + 32'h04, 32'h0, 4'hF);
      bus_wr(BASE + 32'h00, 32'h1, 4'hF);
      repeat (8'h50) @(posedge clk);
      #1;
      check("pre_rst_led0", 32'(LED[0]), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrst_led", 32'(LED), 32'd0);
      check("midrst_dbg", 32'(DEBUG_LED), 32'd0);
      check("midrst_ready", 32'(mem_ready), 32'd0);
      reset = 1'b0;
      bus_rd(BASE + 32'h08, 32'h0, 32'hFFFF_FFFF);
      bus_rd(BASE + 32'h10, 32'h0, 32'hFFFF_FFFF);
      bus_rd(BASE + 32'h18, 32'h0, 32'hFFFF_FFFF);
      bus_rd(BASE + 32'h00, 32'h0, 32'hFFFF_FFFF);

      w = 0;
      while (exp_q.size() != 0 && w < 20) begin
         @(posedge clk);
         w++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
